// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: divider FSM states, default width
// and the width of the iteration counter.
package arith_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LDM  = 3'd1,
    ST_PREP = 3'd2,
    ST_ITER = 3'd3,
    ST_FIX  = 3'd4,
    ST_DONE = 3'd5
  } div_state_t;

  // The counter must hold the value WIDTH itself, hence one extra bit.
  function automatic int div_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/divider_controller.sv
// Sequencing FSM for the restoring divider: turns start/zero/count status
// into one-cycle datapath strobes and drives busy/done.
module divider_controller
  import arith_pkg::*;
(
  input  logic clk,
  input  logic clr_n,
  input  logic start,
  input  logic div_zero,
  input  logic count_last,
  output logic load_op,
  output logic load_divisor,
  output logic prep,
  output logic step,
  output logic fix,
  output logic busy,
  output logic done
);

  div_state_t state_reg;
  div_state_t state_next;

  // State register; reset returns to IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a zero divisor bypasses the iteration and sign fix.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_LDM;
      ST_LDM:  state_next = ST_PREP;
      ST_PREP: state_next = div_zero ? ST_DONE : ST_ITER;
      ST_ITER: if (count_last) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign load_op      = (state_reg == ST_IDLE) && start;
  assign load_divisor = (state_reg == ST_LDM);
  assign prep         = (state_reg == ST_PREP);
  assign step         = (state_reg == ST_ITER);
  assign fix          = (state_reg == ST_FIX);
  assign done         = (state_reg == ST_DONE);
  assign busy         = (state_reg != ST_IDLE);

endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider, signed or unsigned, one quotient bit per
// cycle. Dividend then divisor arrive on data_in in consecutive cycles;
// results are held until the next operation overwrites them.
module restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = div_cnt_width(WIDTH);

  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             signed_reg;
  logic             q_neg_reg;
  logic             r_neg_reg;
  logic [WIDTH-1:0] quot_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             dbz_reg;

  logic             load_op;
  logic             load_divisor;
  logic             prep;
  logic             step;
  logic             fix;
  logic             div_zero;
  logic             count_last;
  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH+1:0] a_shift;
  logic [WIDTH+1:0] diff;

  divider_controller u_ctrl (
    .clk          (clk),
    .clr_n        (clr_n),
    .start        (start),
    .div_zero     (div_zero),
    .count_last   (count_last),
    .load_op      (load_op),
    .load_divisor (load_divisor),
    .prep         (prep),
    .step         (step),
    .fix          (fix),
    .busy         (busy),
    .done         (done)
  );

  // Operand signs only matter in signed mode; in unsigned mode the MSB is data.
  assign dividend_neg = signed_reg && q_reg[WIDTH-1];
  assign divisor_neg  = signed_reg && m_reg[WIDTH-1];
  assign div_zero     = (m_reg == '0);
  assign count_last   = (cnt_reg == CNT_W'(1));

  // Shifted partial remainder and trial subtraction; two guard bits keep the
  // sign of the difference exact even when A reaches its widest value.
  assign a_shift = {a_reg, q_reg[WIDTH-1]};
  assign diff    = a_shift - {2'b00, m_reg};

  // Operand capture, magnitude preparation and the restoring iteration.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      a_reg      <= '0;
      q_reg      <= '0;
      m_reg      <= '0;
      cnt_reg    <= '0;
      signed_reg <= 1'b0;
      q_neg_reg  <= 1'b0;
      r_neg_reg  <= 1'b0;
    end else begin
      if (load_op) begin
        q_reg      <= data_in;
        signed_reg <= signed_op;
      end
      if (load_divisor) begin
        m_reg <= data_in;
      end
      if (prep && !div_zero) begin
        a_reg     <= '0;
        q_reg     <= dividend_neg ? -q_reg : q_reg;
        m_reg     <= divisor_neg ? -m_reg : m_reg;
        cnt_reg   <= CNT_W'(WIDTH);
        q_neg_reg <= dividend_neg ^ divisor_neg;
        r_neg_reg <= dividend_neg;
      end
      if (step) begin
        // Negative difference: keep the shifted A (restore), quotient bit 0.
        a_reg   <= diff[WIDTH+1] ? a_shift[WIDTH:0] : diff[WIDTH:0];
        q_reg   <= {q_reg[WIDTH-2:0], ~diff[WIDTH+1]};
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

  // Visible results: written only by the sign fix or the zero-divisor path,
  // so a partially computed value never reaches the outputs.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      quot_reg <= '0;
      rem_reg  <= '0;
      dbz_reg  <= 1'b0;
    end else begin
      if (load_op) begin
        dbz_reg <= 1'b0;
      end
      if (prep && div_zero) begin
        quot_reg <= '1;
        rem_reg  <= q_reg;
        dbz_reg  <= 1'b1;
      end
      if (fix) begin
        quot_reg <= q_neg_reg ? -q_reg : q_reg;
        rem_reg  <= r_neg_reg ? -a_reg[WIDTH-1:0] : a_reg[WIDTH-1:0];
      end
    end
  end

  assign quotient    = quot_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider: an arithmetic reference model drives
// a per-cycle compare process; hand-computed vectors pin the model.
module tb_restoring_divider;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic        signed_op;
  logic [15:0] data_in;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [15:0] quotient;
  logic [15:0] remainder;

  int total = 0;
  int bad   = 0;

  int edge_cnt = 0;
  bit chk_en   = 0;

  // Reference state for the operation in flight and the result before it.
  bit          op_valid     = 0;
  int          op_e0        = 0;
  int          op_done_edge = 0;
  logic [15:0] new_q = '0, new_r = '0, old_q = '0, old_r = '0;
  logic        new_dbz = 0, old_dbz = 0;
  int          done_seen_edge = -1;

  restoring_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .start       (start),
    .signed_op   (signed_op),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  // Plain arithmetic reference: SV integer division truncates toward zero and
  // the remainder takes the dividend's sign.
  function automatic void model_div(input logic [15:0] a, input logic [15:0] b,
                                    input logic s, output logic [15:0] q,
                                    output logic [15:0] r, output logic z);
    int sa, sb;
    if (b == 16'd0) begin
      q = 16'hFFFF; r = a; z = 1'b1;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q = 16'(sa / sb);
      r = 16'(sa % sb);
      z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Per-cycle compare against the model, sampled after the falling edge.
  always @(negedge clk) begin
    int  k;
    bit  active;
    logic [15:0] eq, er;
    logic ez, eb, ed;
    #1;
    if (chk_en) begin
      k      = edge_cnt;
      active = op_valid && (k >= op_e0);
      eb     = active && (k <= op_done_edge);
      ed     = active && (k == op_done_edge);
      eq     = (active && k >= op_done_edge) ? new_q : old_q;
      er     = (active && k >= op_done_edge) ? new_r : old_r;
      ez     = active ? ((k >= op_done_edge) ? new_dbz : 1'b0) : old_dbz;
      check("busy", 32'(busy), 32'(eb));
      check("done", 32'(done), 32'(ed));
      check("quotient", 32'(quotient), 32'(eq));
      check("remainder", 32'(remainder), 32'(er));
      check("div_by_zero", 32'(div_by_zero), 32'(ez));
      if (done === 1'b1 && done_seen_edge < 0) done_seen_edge = k;
    end
  end

  task automatic run_op(input string nm, input logic [15:0] dvd, input logic [15:0] dvs,
                        input logic sgn, input logic [15:0] lit_q, input logic [15:0] lit_r,
                        input logic lit_z, input bit pulse, input bit do_rst);
    int lim;
    if (op_valid) begin
      old_q = new_q; old_r = new_r; old_dbz = new_dbz;
    end
    done_seen_edge = -1;
    @(negedge clk);
    start = 1'b1; signed_op = sgn; data_in = dvd;
    @(negedge clk);
    model_div(dvd, dvs, sgn, new_q, new_r, new_dbz);
    op_valid     = 1;
    op_e0        = edge_cnt;
    op_done_edge = edge_cnt + ((dvs == 16'd0) ? 2 : 19);
    start = pulse; signed_op = ~sgn; data_in = dvs;
    lim = op_done_edge + 1;
    forever begin
      @(negedge clk);
      if (do_rst && edge_cnt == op_e0 + 9) begin
        clr_n = 1'b0;
      end else if (!clr_n) begin
        clr_n = 1'b1;
        op_valid = 0;
        old_q = '0; old_r = '0; old_dbz = 1'b0;
        break;
      end
      if (edge_cnt >= lim) break;
      data_in = 16'($urandom);
      start   = pulse ? 1'($urandom) : 1'b0;
    end
    start = 1'b0;
    if (!do_rst) begin
      check({nm, " lit quotient"}, 32'(quotient), 32'(lit_q));
      check({nm, " lit remainder"}, 32'(remainder), 32'(lit_r));
      check({nm, " lit div_by_zero"}, 32'(div_by_zero), 32'(lit_z));
      check({nm, " latency"}, 32'(done_seen_edge - op_e0), lit_z ? 32'd2 : 32'd19);
    end
    $display("op %s: %h / %h signed=%0d -> q=%h r=%h dz=%0d", nm, dvd, dvs, sgn,
             quotient, remainder, div_by_zero);
  endtask

  initial begin
    clr_n = 1'b0; start = 1'b0; signed_op = 1'b0; data_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);

    run_op("s 100/7",      16'd100,  16'd7,    1'b1, 16'h000E, 16'h0002, 1'b0, 0, 0);
    run_op("s -100/7",     16'hFF9C, 16'd7,    1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 0, 0);
    run_op("s 100/-7",     16'd100,  16'hFFF9, 1'b1, 16'hFFF2, 16'h0002, 1'b0, 0, 0);
    run_op("s -100/-7",    16'hFF9C, 16'hFFF9, 1'b1, 16'h000E, 16'hFFFE, 1'b0, 0, 0);
    run_op("u FFFF/2",     16'hFFFF, 16'd2,    1'b0, 16'h7FFF, 16'h0001, 1'b0, 0, 0);
    run_op("s min/-1",     16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 0, 0);
    run_op("u 8000/3",     16'h8000, 16'd3,    1'b0, 16'h2AAA, 16'h0002, 1'b0, 0, 0);
    run_op("s 8000/3",     16'h8000, 16'd3,    1'b1, 16'hD556, 16'hFFFE, 1'b0, 0, 0);
    run_op("u 50/0",       16'd50,   16'd0,    1'b0, 16'hFFFF, 16'h0032, 1'b1, 0, 0);
    run_op("s -100/0",     16'hFF9C, 16'd0,    1'b1, 16'hFFFF, 16'hFF9C, 1'b1, 0, 0);
    run_op("u 1000/10 pulsed", 16'd1000, 16'd10, 1'b0, 16'h0064, 16'h0000, 1'b0, 1, 0);
    run_op("u 777/5 reset", 16'd777, 16'd5,    1'b0, 16'h0000, 16'h0000, 1'b0, 0, 1);
    run_op("u 9/3",        16'd9,    16'd3,    1'b0, 16'h0003, 16'h0000, 1'b0, 0, 0);
    run_op("u 65535/255",  16'hFFFF, 16'h00FF, 1'b0, 16'h0101, 16'h0000, 1'b0, 0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
